// File: rtl/oled_spi_arb_if.sv
// Bundle of signals between the OLED SPI arbiter, its requester FSMs and spi_ctrl.
// The master side is the requesters plus spi_ctrl; the slave side is the arbiter.
interface oled_spi_arb_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   lock;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_dc;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   ack;
    logic              busy;
    logic              err;
    logic              spi_en;
    logic [7:0]        spi_data;
    logic              spi_fin;
    logic              dc;

    modport master (
        output req, lock, req_data, req_dc, spi_fin,
        input  grant, ack, busy, err, spi_en, spi_data, dc
    );

    modport slave (
        input  req, lock, req_data, req_dc, spi_fin,
        output grant, ack, busy, err, spi_en, spi_data, dc
    );
endinterface

// File: rtl/oled_spi_arb.sv
// Round-robin arbiter sharing one spi_ctrl byte engine and the OLED D/C line
// among NREQ requesters, with a lock input to keep ownership across a burst.
// Optional SEND watchdog enabled by defining OLED_ARB_TIMEOUT_EN.
module oled_spi_arb #(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic           clk,
    input  logic           rst,
    oled_spi_arb_if.slave  bus
);
    localparam int IW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {ARB, SEND, DONE} state_t;

    // Reject unsupported configurations at elaboration.
    if (NREQ < 2 || NREQ > 4 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_bad_cfg
        $fatal(1, "oled_spi_arb: NREQ must be 2..4 and TIMEOUT_CYC 2..65536");
    end

    state_t          state, state_n;
    logic [IW-1:0]   rr, rr_n;
    logic            rr_init, rr_init_n;
    logic            lock_held, lock_held_n;
    logic [NREQ-1:0] grant, grant_n;
    logic [NREQ-1:0] ack, ack_n;
    logic            spi_en, spi_en_n;
    logic [7:0]      spi_data, spi_data_n;
    logic            dc, dc_n;
    logic [7:0]      data_arr [NREQ];
    logic            found;
    logic [IW-1:0]   winner;
    int              start;
`ifdef OLED_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic            err, err_n;
    logic [15:0]     count, count_n;
`endif

    // Split the packed request bytes into a per-requester array.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            data_arr[i] = bus.req_data[8*i +: 8];
        end
    end

    // Pick the winner: the locked owner if still requesting, else the first
    // request after the last winner (rr_init makes the first scan start at 0).
    always_comb begin
        found  = 1'b0;
        winner = rr;
        start  = 0;
        if (lock_held && bus.req[rr]) begin
            found = 1'b1;
        end else begin
            start = rr_init ? 0 : (int'(rr) + 1) % NREQ;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && bus.req[IW'((start + k) % NREQ)]) begin
                    found  = 1'b1;
                    winner = IW'((start + k) % NREQ);
                end
            end
        end
    end

    // Next-state and next-output logic for the ARB/SEND/DONE sequence.
    always_comb begin
        state_n     = state;
        rr_n        = rr;
        rr_init_n   = rr_init;
        lock_held_n = lock_held;
        grant_n     = grant;
        ack_n       = ack;
        spi_en_n    = spi_en;
        spi_data_n  = spi_data;
        dc_n        = dc;
`ifdef OLED_ARB_TIMEOUT_EN
        err_n       = 1'b0;
        count_n     = count;
`endif
        case (state)
            ARB: begin
                ack_n = '0;
                if (lock_held && !bus.req[rr]) begin
                    lock_held_n = 1'b0;
                end
                if (found) begin
                    grant_n         = '0;
                    grant_n[winner] = 1'b1;
                    spi_data_n      = data_arr[winner];
                    dc_n            = bus.req_dc[winner];
                    spi_en_n        = 1'b1;
                    rr_n            = winner;
                    rr_init_n       = 1'b0;
                    state_n         = SEND;
`ifdef OLED_ARB_TIMEOUT_EN
                    count_n         = '0;
`endif
                end else if (!lock_held) begin
                    grant_n = '0;
                end
            end
            SEND: begin
                if (bus.spi_fin) begin
                    spi_en_n    = 1'b0;
                    ack_n       = '0;
                    ack_n[rr]   = 1'b1;
                    lock_held_n = bus.lock[rr];
                    state_n     = DONE;
                end
`ifdef OLED_ARB_TIMEOUT_EN
                else if (count == TO_LAST) begin
                    spi_en_n    = 1'b0;
                    err_n       = 1'b1;
                    ack_n       = '0;
                    ack_n[rr]   = 1'b1;
                    lock_held_n = 1'b0;
                    state_n     = DONE;
                end else begin
                    count_n = count + 16'd1;
                end
`endif
            end
            DONE: begin
                ack_n   = '0;
                state_n = ARB;
            end
            default: state_n = ARB;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB;
            rr        <= '0;
            rr_init   <= 1'b1;
            lock_held <= 1'b0;
            grant     <= '0;
            ack       <= '0;
            spi_en    <= 1'b0;
            spi_data  <= '0;
            dc        <= 1'b0;
`ifdef OLED_ARB_TIMEOUT_EN
            err       <= 1'b0;
            count     <= '0;
`endif
        end else begin
            state     <= state_n;
            rr        <= rr_n;
            rr_init   <= rr_init_n;
            lock_held <= lock_held_n;
            grant     <= grant_n;
            ack       <= ack_n;
            spi_en    <= spi_en_n;
            spi_data  <= spi_data_n;
            dc        <= dc_n;
`ifdef OLED_ARB_TIMEOUT_EN
            err       <= err_n;
            count     <= count_n;
`endif
        end
    end

    assign bus.grant    = grant;
    assign bus.ack      = ack;
    assign bus.spi_en   = spi_en;
    assign bus.spi_data = spi_data;
    assign bus.dc       = dc;
    assign bus.busy     = (state != ARB);
`ifdef OLED_ARB_TIMEOUT_EN
    assign bus.err      = err;
`else
    assign bus.err      = 1'b0;
`endif
endmodule
